// File: rtl/pb_mode_ctrl.sv
// Pushbutton mode controller: synchronizes and debounces NUM_CH buttons, then
// toggles independent mode flags or drives a radio-button group from accepted presses.
module pb_mode_ctrl #(
   parameter int NUM_CH    = 4,
   parameter int DB_CYCLES = 4,
   parameter int EXCLUSIVE = 0
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic              sync_reset,
   input  logic [NUM_CH-1:0] pb,
   output logic [NUM_CH-1:0] flags,
   output logic [NUM_CH-1:0] press_pulse,
   output logic              changed
);

   localparam int             CW      = $clog2(DB_CYCLES + 1);
   localparam logic [CW-1:0]  CNT_MAX = CW'(DB_CYCLES);

   logic [NUM_CH-1:0] rise;
   logic [NUM_CH-1:0] press_q, press_d;
   logic [NUM_CH-1:0] flags_q, flags_d;
   logic              changed_q, changed_d;

   generate
      for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
         logic          sync1_q, sync2_q, db_q, db_d, rise_d;
         logic [CW-1:0] cnt_q, cnt_d;

         // Counter only ever reaches CNT_MAX while the level still disagrees,
         // so the accept edge is the (DB_CYCLES+1)-th disagreeing sample.
         always_comb begin
            cnt_d  = cnt_q;
            db_d   = db_q;
            rise_d = 1'b0;
            if (sync2_q == db_q) begin
               cnt_d = '0;
            end else if (cnt_q == CNT_MAX) begin
               db_d   = sync2_q;
               cnt_d  = '0;
               rise_d = sync2_q;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end

         always_ff @(posedge clk or negedge nrst) begin
            if (!nrst) begin
               sync1_q <= 1'b0;
               sync2_q <= 1'b0;
               db_q    <= 1'b0;
               cnt_q   <= '0;
            end else begin
               sync1_q <= pb[gi];
               sync2_q <= sync1_q;
               db_q    <= db_d;
               cnt_q   <= cnt_d;
            end
         end

         assign rise[gi] = rise_d;
      end
   endgenerate

   always_comb begin
      logic [NUM_CH-1:0] win;
      logic              found;
      press_d = rise;
      flags_d = flags_q;
      win     = '0;
      found   = 1'b0;
      if (EXCLUSIVE != 0) begin
         // Lowest-index pulsing channel owns the group this cycle.
         for (int i = 0; i < NUM_CH; i++) begin
            if (press_q[i] && !found) begin
               found  = 1'b1;
               win[i] = 1'b1;
            end
         end
         if (found) begin
            flags_d = (|(flags_q & win)) ? '0 : win;
         end
      end else begin
         flags_d = flags_q ^ press_q;
      end
      if (sync_reset) begin
         flags_d = '0;
      end
      changed_d = (flags_d != flags_q);
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         press_q   <= '0;
         flags_q   <= '0;
         changed_q <= 1'b0;
      end else begin
         press_q   <= press_d;
         flags_q   <= flags_d;
         changed_q <= changed_d;
      end
   end

   assign flags       = flags_q;
   assign press_pulse = press_q;
   assign changed     = changed_q;

endmodule

// File: tb/tb_pb_mode_ctrl.sv
// Bench for pb_mode_ctrl: two instances (independent and exclusive) share inputs and are
// compared every cycle against a sliding-window debounce model, plus literal directed checks.
module tb_pb_mode_ctrl;

   localparam int NCH = 4;
   localparam int DB  = 4;

   logic           clk;
   logic           nrst;
   logic           sync_reset;
   logic [NCH-1:0] pb;
   logic [NCH-1:0] flags0, pp0, flags1, pp1;
   logic           ch0, ch1;

   int errs   = 0;
   int checks = 0;

   pb_mode_ctrl #(.NUM_CH(NCH), .DB_CYCLES(DB), .EXCLUSIVE(0)) u_dut0 (
      .clk(clk), .nrst(nrst), .sync_reset(sync_reset), .pb(pb),
      .flags(flags0), .press_pulse(pp0), .changed(ch0)
   );

   pb_mode_ctrl #(.NUM_CH(NCH), .DB_CYCLES(DB), .EXCLUSIVE(1)) u_dut1 (
      .clk(clk), .nrst(nrst), .sync_reset(sync_reset), .pb(pb),
      .flags(flags1), .press_pulse(pp1), .changed(ch1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Inputs change 3 time units after posedge, so they are stable when sampled here.
   logic [NCH-1:0] samp_pb;
   logic           samp_sr;
   int             edge_cnt = 0;
   always @(posedge clk) begin
      if (nrst) begin
         samp_pb  <= pb;
         samp_sr  <= sync_reset;
         edge_cnt <= edge_cnt + 1;
      end
   end

   // Model: synchronized level is the raw sample from two edges ago; a channel
   // accepts a new level once the last DB+1 synchronized samples all disagree with it.
   logic [NCH-1:0] pbh[$];
   logic [NCH-1:0] lvh[$];
   logic [NCH-1:0] mdb, mpp, mf0, mf1, old0, old1, newpp, lvl;
   logic           mc0, mc1, stable;
   int             done_cnt = 0;
   int             win;

   initial begin
      forever begin
         @(negedge clk);
         if (!nrst) begin
            pbh.delete();
            lvh.delete();
            mdb = '0; mpp = '0; mf0 = '0; mf1 = '0; mc0 = 1'b0; mc1 = 1'b0;
            done_cnt = edge_cnt;
            chk("rst_outputs", {pp0, pp1, flags0, flags1, 6'd0, ch0, ch1}, 32'd0);
         end else if (edge_cnt != done_cnt) begin
            done_cnt = edge_cnt;
            pbh.push_back(samp_pb);
            if (pbh.size() > 3) void'(pbh.pop_front());
            lvl = (pbh.size() == 3) ? pbh[0] : '0;
            lvh.push_back(lvl);
            if (lvh.size() > DB + 1) void'(lvh.pop_front());
            old0 = mf0;
            old1 = mf1;
            if (samp_sr) begin
               mf0 = '0;
               mf1 = '0;
            end else begin
               mf0 = mf0 ^ mpp;
               win = -1;
               for (int i = 0; i < NCH; i++) if (mpp[i] && win < 0) win = i;
               if (win >= 0) mf1 = mf1[win] ? '0 : (NCH'(1) << win);
            end
            mc0 = (mf0 != old0);
            mc1 = (mf1 != old1);
            newpp = '0;
            for (int c = 0; c < NCH; c++) begin
               stable = (lvh.size() == DB + 1);
               for (int k = 0; k < lvh.size(); k++) if (lvh[k][c] == mdb[c]) stable = 1'b0;
               if (stable) begin
                  mdb[c]   = ~mdb[c];
                  newpp[c] = mdb[c];
               end
            end
            mpp = newpp;
            chk("pulse_ind", pp0, mpp);
            chk("pulse_exc", pp1, mpp);
            chk("flags_ind", flags0, mf0);
            chk("flags_exc", flags1, mf1);
            chk("changed_ind", ch0, mc0);
            chk("changed_exc", ch1, mc1);
            checks++;
            if ($countones(flags1) > 1) begin
               errs++;
               $display("FAIL onehot_exc actual=%0h required=at most one bit", flags1);
            end
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #3;
   endtask

   task automatic press(input logic [NCH-1:0] m);
      pb = m;
      step(20);
      pb = '0;
      step(10);
   endtask

   logic [NCH-1:0] acc;
   logic           cacc;
   int             rem[NCH];
   logic [NCH-1:0] rlvl;

   initial begin
      nrst = 1'b1; pb = '0; sync_reset = 1'b0;
      #2 nrst = 1'b0;
      #1 chk("reset_flags", {flags0, flags1}, 8'h00);
      chk("reset_pulse", {pp0, pp1, ch0, ch1}, 10'h000);
      repeat (3) @(posedge clk);
      #3 nrst = 1'b1;
      step(4);
      chk("idle_after_release", {flags0, flags1, pp0, pp1, ch0, ch1}, 18'h0);

      // Basic press latency on channel 0
      pb = 4'b0001;
      repeat (6) @(posedge clk);
      #1 chk("t1_no_pulse_edge6", pp0, 4'b0000);
      @(posedge clk);
      #1 chk("t1_pulse_edge7", pp0, 4'b0001);
      chk("t1_pulse_edge7_exc", pp1, 4'b0001);
      chk("t1_flags_edge7", flags0, 4'b0000);
      @(posedge clk);
      #1 chk("t1_flags_edge8", flags0, 4'b0001);
      chk("t1_changed_edge8", ch0, 1'b1);
      chk("t1_flags_exc", flags1, 4'b0001);
      chk("t1_pulse_gone", pp0, 4'b0000);
      @(posedge clk);
      #1 chk("t1_changed_once", ch0, 1'b0);
      #2 step(11);
      pb = '0;
      step(10);
      press(4'b0001);
      chk("t1_second_press", flags0, 4'b0000);
      chk("t1_second_press_exc", flags1, 4'b0000);

      // Short bounce on channel 1 is rejected
      acc = '0; cacc = 1'b0;
      for (int k = 0; k < 16; k++) begin
         pb = (k < 6 && (k % 2) == 0) ? 4'b0010 : 4'b0000;
         @(posedge clk);
         #1 acc = acc | pp0;
         cacc = cacc | ch0 | ch1;
         #2;
      end
      chk("t2_no_pulse", acc, 4'b0000);
      chk("t2_no_changed", cacc, 1'b0);
      chk("t2_flags", flags0, 4'b0000);

      // Radio group sequence
      press(4'b0100);
      chk("t3_ch2_exc", flags1, 4'b0100);
      chk("t3_ch2_ind", flags0, 4'b0100);
      press(4'b0001);
      chk("t3_ch0_exc", flags1, 4'b0001);
      chk("t3_ch0_ind", flags0, 4'b0101);
      press(4'b0001);
      chk("t3_ch0_again_exc", flags1, 4'b0000);
      chk("t3_ch0_again_ind", flags0, 4'b0100);
      press(4'b1010);
      chk("t3_ch1_ch3_exc", flags1, 4'b0010);
      chk("t3_ch1_ch3_ind", flags0, 4'b1110);

      // sync_reset coinciding with a press pulse
      press(4'b0100);
      chk("t4_setup_ind", flags0, 4'b1010);
      chk("t4_setup_exc", flags1, 4'b0100);
      pb = 4'b0001;
      repeat (7) @(posedge clk);
      #1 chk("t4_pulse_seen", pp0, 4'b0001);
      #2 sync_reset = 1'b1;
      @(posedge clk);
      #1 chk("t4_flags_cleared", flags0, 4'b0000);
      chk("t4_changed", ch0, 1'b1);
      chk("t4_flags_cleared_exc", flags1, 4'b0000);
      chk("t4_changed_exc", ch1, 1'b1);
      #2 sync_reset = 1'b0;
      @(posedge clk);
      #1 chk("t4_changed_once", ch0, 1'b0);
      #2 step(12);
      pb = '0;
      step(10);

      // Reset in the middle of a debounce with the button still held
      press(4'b0010);
      chk("t5_setup", flags0, 4'b0010);
      pb = 4'b1000;
      step(4);
      nrst = 1'b0;
      #1 chk("t5_async_clear", {flags0, flags1, pp0, pp1, ch0, ch1}, 18'h0);
      #2 step(2);
      nrst = 1'b1;
      repeat (6) @(posedge clk);
      #1 chk("t5_no_pulse_edge6", pp0, 4'b0000);
      @(posedge clk);
      #1 chk("t5_pulse_edge7", pp0, 4'b1000);
      chk("t5_pulse_edge7_exc", pp1, 4'b1000);
      @(posedge clk);
      #1 chk("t5_flags", flags0, 4'b1000);
      chk("t5_flags_exc", flags1, 4'b1000);
      acc = '0;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk);
         #1 acc = acc | pp0;
      end
      chk("t5_single_pulse", acc, 4'b0000);
      #2 pb = '0;
      step(10);

      // Random bouncing traffic checked by the model every cycle
      rlvl = '0;
      for (int i = 0; i < NCH; i++) rem[i] = 0;
      for (int c = 0; c < 2500; c++) begin
         for (int i = 0; i < NCH; i++) begin
            if (rem[i] == 0) begin
               if ($urandom_range(0, 3) == 0) rem[i] = int'($urandom_range(1, 4));
               else rem[i] = int'($urandom_range(5, 30));
               rlvl[i] = ~rlvl[i];
            end
            rem[i]--;
         end
         pb = rlvl;
         sync_reset = ($urandom_range(0, 99) < 3);
         if (c == 1200) nrst = 1'b0;
         if (c == 1203) nrst = 1'b1;
         step(1);
      end
      pb = '0;
      sync_reset = 1'b0;
      step(12);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/pb_mode_ctrl.md
PB_MODE_CTRL -- requirements
Module: pb_mode_ctrl

Interface
- REQ-001: Parameter NUM_CH, default 4, number of pushbutton channels; legal range 1..16.
- REQ-002: Parameter DB_CYCLES, default 4, consecutive stable cycles required to accept a level change; legal range 1..255.
- REQ-003: Parameter EXCLUSIVE, default 0; 0 = independent toggle per channel, 1 = mutually exclusive (radio-button) group.
- REQ-004: clk  input  1  system clock, all state on rising edge.
- REQ-005: nrst  input  1  asynchronous, active-low reset.
- REQ-006: sync_reset  input  1  synchronous clear of flags, active-high.
- REQ-007: pb  input  NUM_CH  raw asynchronous pushbutton levels, active-high.
- REQ-008: flags  output  NUM_CH  registered mode flags.
- REQ-009: press_pulse  output  NUM_CH  registered one-cycle pulse per accepted press.
- REQ-010: changed  output  1  registered one-cycle pulse whenever flags changes value.

Function
- REQ-011: Each pb bit SHALL pass through a two-flop synchronizer before any other logic.
- REQ-012: Each channel SHALL hold a debounced state and a saturating counter of width $clog2(DB_CYCLES+1).
- REQ-013: Counter SHALL clear whenever the synchronized level equals the debounced state; otherwise it SHALL increment.
- REQ-014: When the counter reaches DB_CYCLES, the debounced state SHALL take the synchronized level and the counter SHALL clear in the same edge.
- REQ-015: A pb pulse or glitch shorter than DB_CYCLES synchronized cycles SHALL produce no press_pulse and no flags change.
- REQ-016: press_pulse[i] SHALL be high for exactly one cycle following a debounced 0->1 transition; release (1->0) SHALL produce no pulse.
- REQ-017: Holding pb high indefinitely SHALL produce one press_pulse only; the next pulse requires a debounced release then a new debounced press.
- REQ-018: flags SHALL update on the edge at which press_pulse is high (i.e. flags reflects the press one cycle after press_pulse asserts).
- REQ-019: Latency SHALL be fixed: counting the first clk edge that samples pb high as edge 1, press_pulse asserts after edge DB_CYCLES+3 and flags changes after edge DB_CYCLES+4.
- REQ-020: EXCLUSIVE=0: each press_pulse[i] SHALL invert flags[i]; simultaneous pulses on several channels SHALL all toggle their own bits.
- REQ-021: EXCLUSIVE=1: press on channel i with flags[i]=0 SHALL set flags to one-hot bit i; with flags[i]=1 SHALL clear flags to 0.
- REQ-022: EXCLUSIVE=1 with simultaneous pulses: lowest-index pulsing channel SHALL win; others ignored for that cycle.
- REQ-023: EXCLUSIVE=1: flags SHALL never have more than one bit set.
- REQ-024: sync_reset SHALL clear flags to 0 on the next edge and take priority over any same-cycle press; synchronizers, debounce state and press_pulse SHALL be unaffected.
- REQ-025: changed SHALL assert for one cycle, aligned with the new flags value, whenever flags differs from its previous value (including sync_reset from nonzero); no pulse when sync_reset hits flags already 0.

Reset
- REQ-026: nrst low SHALL asynchronously clear synchronizers, debounced states, counters, flags, press_pulse and changed to 0.
- REQ-027: Reset deassertion mid-press SHALL treat a held-high pb as a new press, subject to full debounce latency.
- REQ-028: No output SHALL glitch or pulse during or immediately at reset release absent a debounced press.

Verification
- REQ-029: DB_CYCLES=4, EXCLUSIVE=0: pb[0] high 20 cycles -> press_pulse[0] one cycle after edge 7, flags=4'b0001 after edge 8, changed one pulse; second identical press -> flags=4'b0000.
- REQ-030: pb[1] high for 3 cycles, bouncing 1-0-1-0 at 1-cycle period -> no press_pulse, flags unchanged, changed never asserts.
- REQ-031: EXCLUSIVE=1: press ch2 -> flags=4'b0100; press ch0 -> 4'b0001; press ch0 again -> 4'b0000; simultaneous ch1 and ch3 -> 4'b0010.
- REQ-032: flags=4'b1010, sync_reset in same cycle as press_pulse[0] -> flags=4'b0000, changed pulses once; press_pulse[0] still observed.
- REQ-033: nrst asserted while pb[3] held mid-debounce -> all outputs 0 immediately; after release with pb[3] still high -> exactly one press_pulse[3] after DB_CYCLES+3 edges.
- REQ-034: Random stimulus on all channels, both EXCLUSIVE values: checker SHALL confirm REQ-017, REQ-023 and exact REQ-019 latency on every accepted press.
